alu_issue: RTL
==============

ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-002 SHALL have port rst, input, 1, reset; synchronous and active-high.
REQ-003 SHALL have port flush, input, 1, discards all buffered and arriving instructions.
REQ-004 SHALL have port in_valid, input, 1, upstream instruction present.
REQ-005 SHALL have port in_ready, output, 1, stage accepts; registered output.
REQ-006 SHALL have port opcode, input, 7, RV32I opcode.
REQ-007 SHALL have port funct3, input, 3, RV32I funct3.
REQ-008 SHALL have port funct7_5, input, 1, instruction bit 30.
REQ-009 SHALL have ports rs1_data, rs2_data, imm and pc, each input, 32, operands, sign-extended immediate and instruction address.
REQ-010 SHALL have port out_valid, output, 1, ALU request present.
REQ-011 SHALL have port out_ready, input, 1, ALU side accepts.
REQ-012 SHALL have port alu_op, output, 3, ALU_OP code.
REQ-013 SHALL have ports alu_in1 and alu_in2, each output, 32, ALU operands.
REQ-014 SHALL have port illegal, output, 1, decode failed for this entry.

Function
REQ-015 SHALL decode opcode 0110011 (OP) as follows: funct3 000 gives SUB if funct7_5 else ADD; 100 gives XOR; 110 gives OR; 111 gives AND; in1=rs1_data, in2=rs2_data.
REQ-016 SHALL decode opcode 0010011 (OP-IMM) with the same funct3 map, always ADD for 000 (funct7_5 ignored), in1=rs1_data, in2=imm.
REQ-017 SHALL decode LOAD 0000011 and STORE 0100011 as ADD with in1=rs1_data and in2=imm.
REQ-018 SHALL decode LUI 0110111 as ADD with in1=0 and in2=imm; AUIPC 0010111 as ADD with in1=pc and in2=imm; BRANCH 1100011 as SUB with in1=rs1_data and in2=rs2_data.
REQ-019 SHALL set illegal=1, alu_op=ADD and both operands to 0 for any other opcode or unsupported funct3 (001, 010, 011, 101); such an entry still flows through the handshake.
REQ-020 SHALL decode combinationally at input and store the decoded {alu_op, in1, in2, illegal} in a two-entry skid buffer.
REQ-021 SHALL use a state machine with states EMPTY, ONE and FULL.
REQ-022 SHALL make transfers: input on in_valid&&in_ready, output on out_valid&&out_ready.
REQ-023 SHALL transition EMPTY->ONE on input; ONE->FULL on input without output; ONE->EMPTY on output without input; ONE->ONE on both; FULL->ONE on output.
REQ-024 SHALL drive in_ready=1 in EMPTY and ONE and 0 in FULL, so no input is accepted in FULL even if output occurs that cycle.
REQ-025 SHALL drive out_valid=1 in ONE and FULL; outputs SHALL come from the oldest entry in order, with latency of one cycle from input to out_valid.
REQ-026 SHALL hold output fields stable while out_valid=1 and out_ready=0.
REQ-027 SHALL on flush=1 go to EMPTY next cycle and drop any same-cycle input, so no flushed instruction ever appears at the output; flush has priority over all transfers.
REQ-028 SHALL perform no arithmetic beyond selection; all data 32 bits, no width changes.

Reset
REQ-029 SHALL on rst=1 at a clock edge enter EMPTY with out_valid=0, in_ready=1, alu_op=ADD, alu_in1=0, alu_in2=0 and illegal=0; rst overrides flush and mid-transfer activity.

Structure
REQ-030 SHALL import ALU op codes from the shared ALU_OP package; opcode constants (OP, OP_IMM, LOAD, STORE, LUI, AUIPC, BRANCH) and the buffer-state enum SHALL be added to a shared package RV32I_PKG.
REQ-031 SHALL place decode in sub-module alu_decode (combinational) with the skid buffer in alu_issue.

Verification
REQ-032 SHALL verify OP SUB: rs1=5, rs2=7, funct3=000, funct7_5=1 gives next cycle out_valid=1, alu_op=SUB, in1=5, in2=7, illegal=0.
REQ-033 SHALL verify AUIPC: pc=0x1000 and imm=0x2000 gives alu_op=ADD, in1=0x1000, in2=0x2000.
REQ-034 SHALL verify backpressure: out_ready=0 with 3 valid inputs gives in_ready=0 after 2 accepted; on releasing out_ready the outputs appear in order with no loss or duplication.
REQ-035 SHALL verify illegal decode: OP with funct3=001 gives illegal=1, alu_op=ADD, in1=in2=0.
REQ-036 SHALL verify flush in FULL with simultaneous in_valid: the next cycle is EMPTY, out_valid=0 and in_ready=1, and the flushed data is never output.
REQ-037 SHALL verify reset asserted in FULL: the next cycle gives out_valid=0, in_ready=1 and all outputs zero with alu_op=ADD.

Source files
------------

// File: rtl/alu_op_pkg.sv
// alu_op_pkg: ALU operation codes shared by every ALU producer and consumer.
package alu_op_pkg;
  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_XOR = 3'd2,
    ALU_OR  = 3'd3,
    ALU_AND = 3'd4
  } alu_op_t;
endpackage

// File: rtl/rv32i_pkg.sv
// rv32i_pkg: RV32I opcode constants, issue-buffer states and decoded-entry type.
package rv32i_pkg;
  import alu_op_pkg::*;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  typedef enum logic [1:0] {EMPTY, ONE, FULL} buf_state_t;
  typedef struct packed {
    alu_op_t     op;
    logic [31:0] in1;
    logic [31:0] in2;
    logic        illegal;
  } dec_t;
  localparam dec_t DEC_NOP = '{op: ALU_ADD, in1: '0, in2: '0, illegal: 1'b0};
  localparam dec_t DEC_ILL = '{op: ALU_ADD, in1: '0, in2: '0, illegal: 1'b1};
  function automatic logic f3_ok(input logic [2:0] f3);
    return f3 == 3'b000 || f3 == 3'b100 || f3 == 3'b110 || f3 == 3'b111;
  endfunction
  function automatic alu_op_t f3_op(input logic [2:0] f3, input logic sub);
    return f3 == 3'b000 ? (sub ? ALU_SUB : ALU_ADD) :
           f3 == 3'b100 ? ALU_XOR :
           f3 == 3'b110 ? ALU_OR : ALU_AND;
  endfunction
endpackage

// File: rtl/alu_issue_decode.sv
// alu_decode: combinational RV32I decode into an ALU op and selected operands.
module alu_decode
  import alu_op_pkg::*;
  import rv32i_pkg::*;
(
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic        funct7_5,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  input  logic [31:0] imm,
  input  logic [31:0] pc,
  output dec_t        dec
);
  always_comb begin
    dec = DEC_ILL;
    case (opcode)
      OPC_OP:     dec = f3_ok(funct3) ? dec_t'{f3_op(funct3, funct7_5), rs1_data, rs2_data, 1'b0} : DEC_ILL;
      OPC_OP_IMM: dec = f3_ok(funct3) ? dec_t'{f3_op(funct3, 1'b0), rs1_data, imm, 1'b0} : DEC_ILL;
      OPC_LOAD,
      OPC_STORE:  dec = dec_t'{ALU_ADD, rs1_data, imm, 1'b0};
      OPC_LUI:    dec = dec_t'{ALU_ADD, 32'd0, imm, 1'b0};
      OPC_AUIPC:  dec = dec_t'{ALU_ADD, pc, imm, 1'b0};
      OPC_BRANCH: dec = dec_t'{ALU_SUB, rs1_data, rs2_data, 1'b0};
      default:    dec = DEC_ILL;
    endcase
  end
endmodule

// File: rtl/alu_issue.sv
// alu_issue: decodes RV32I ALU-class instructions into a two-entry in-order skid buffer.
module alu_issue
  import alu_op_pkg::*;
  import rv32i_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic        funct7_5,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  input  logic [31:0] imm,
  input  logic [31:0] pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [2:0]  alu_op,
  output logic [31:0] alu_in1,
  output logic [31:0] alu_in2,
  output logic        illegal
);
  buf_state_t state;
  dec_t dec, head, tail;
  logic take, give;
  alu_decode u_dec (
    .opcode(opcode), .funct3(funct3), .funct7_5(funct7_5),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm), .pc(pc), .dec(dec)
  );
  assign take = in_valid && in_ready;
  assign give = out_valid && out_ready;
  assign alu_op = head.op;
  assign alu_in1 = head.in1;
  assign alu_in2 = head.in2;
  assign illegal = head.illegal;
  // head is always the oldest entry and drives the outputs directly.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      state <= EMPTY;
      in_ready <= 1'b1;
      out_valid <= 1'b0;
      head <= DEC_NOP;
    end else begin
      case (state)
        EMPTY: if (take) begin
          head <= dec;
          state <= ONE;
          out_valid <= 1'b1;
        end
        ONE: if (take && give) begin
          head <= dec;
        end else if (take) begin
          tail <= dec;
          state <= FULL;
          in_ready <= 1'b0;
        end else if (give) begin
          state <= EMPTY;
          out_valid <= 1'b0;
        end
        FULL: if (give) begin
          head <= tail;
          state <= ONE;
          in_ready <= 1'b1;
        end
        default: begin
          state <= EMPTY;
          in_ready <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end
endmodule
